// File: rtl/rchdc_pkg.sv
// ============================================================
// rchdc_pkg : shared encodings and FSM states for the RCHDC classifier
// Revision  : 1.0
// ============================================================
`default_nettype none

package rchdc_pkg;
  localparam int CLS_NUM = 10;
  localparam int CLS_DW  = $clog2(CLS_NUM);
  localparam int DIM     = 2048;

  // Datapath state encoding: TRAIN lets set_clr commit the class set into the AM
  localparam logic TRAIN   = 1'b1;
  localparam logic PREDICT = 1'b0;

  typedef enum logic [2:0] {
    FLUSH     = 3'd0,
    IDLE      = 3'd1,
    ACCUM     = 3'd2,
    CLOSE     = 3'd3,
    SET_CLOSE = 3'd4,
    WAIT_PRED = 3'd5,
    RESULT    = 3'd6
  } rchdc_ctrl_state_e;
endpackage

`default_nettype wire

// File: rtl/rchdc_cnt.sv
// ============================================================
// rchdc_cnt : up-counter with clear/enable that wraps to 0 after MAX
// Revision  : 1.0
// ============================================================
`default_nettype none

module rchdc_cnt #(
  parameter int             W   = 8,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == MAX) ? '0 : cnt + 1'b1;
    end
  end
endmodule

`default_nettype wire

// File: rtl/rchdc_seq_ctrl.sv
// ============================================================
// rchdc_seq_ctrl : job sequencer for the RCHDC train/predict datapath
// Option macro   : RCHDC_CTRL_ABORT_EN adds an abort input
// Revision       : 1.0
// ============================================================
`default_nettype none

module rchdc_seq_ctrl
  import rchdc_pkg::*;
#(
  parameter  int FEAT_NUM  = 784,
  parameter  int SMP_CNT_W = 16,
  parameter  int PRED_LAT  = 2,
  localparam int FW        = (FEAT_NUM > 1) ? $clog2(FEAT_NUM) : 1,
  localparam int LW        = (PRED_LAT > 1) ? $clog2(PRED_LAT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef RCHDC_CTRL_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_mode,
  input  logic [CLS_DW-1:0]    cmd_label,
  input  logic [SMP_CNT_W-1:0] cmd_smp_cnt,
  input  logic                 feat_valid,
  output logic                 feat_ready,
  output logic [FW-1:0]        feat_idx,
  output logic                 dp_state,
  output logic                 dp_smp_en,
  output logic                 dp_smp_clr,
  output logic                 dp_set_clr,
  output logic [CLS_DW-1:0]    dp_label,
  input  logic [CLS_DW-1:0]    dp_predict,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CLS_DW-1:0]    res_class,
  output logic [SMP_CNT_W-1:0] res_smp,
  output logic                 busy
);
  rchdc_ctrl_state_e state, state_nx;

  logic                 mode_q;
  logic [SMP_CNT_W-1:0] job_cnt;
  logic [SMP_CNT_W-1:0] smp_idx;
  logic [SMP_CNT_W-1:0] last_idx;
  logic [LW-1:0]        lat_cnt;
  logic                 feat_last, smp_last, lat_last, abort_act;
  logic                 accept, smp_inc, lat_clr, lat_en, capture;

`ifdef RCHDC_CTRL_ABORT_EN
  assign abort_act = abort && (state != FLUSH) && (state != IDLE);
`else
  assign abort_act = 1'b0;
`endif

  assign last_idx  = job_cnt - 1'b1;
  assign smp_last  = (smp_idx == last_idx);
  assign feat_last = (feat_idx == FW'(FEAT_NUM - 1));
  assign lat_last  = (lat_cnt == LW'(PRED_LAT - 1));

  assign dp_smp_en = feat_valid & feat_ready;
  // FLUSH must clear the class encoder without committing, whatever the last job was
  assign dp_state  = (state == FLUSH) ? PREDICT : mode_q;
  assign busy      = (state != IDLE);
  assign res_smp   = smp_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= FLUSH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    cmd_ready  = 1'b0;
    feat_ready = 1'b0;
    dp_smp_clr = 1'b0;
    dp_set_clr = 1'b0;
    res_valid  = 1'b0;
    accept     = 1'b0;
    smp_inc    = 1'b0;
    lat_clr    = 1'b0;
    lat_en     = 1'b0;
    capture    = 1'b0;
    case (state)
      FLUSH: begin
        dp_smp_clr = 1'b1;
        dp_set_clr = 1'b1;
        state_nx   = IDLE;
      end
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_smp_cnt != '0) state_nx = ACCUM;
        end
      end
      ACCUM: begin
        feat_ready = 1'b1;
        if (feat_valid && feat_last) state_nx = CLOSE;
      end
      CLOSE: begin
        dp_smp_clr = 1'b1;
        lat_clr    = 1'b1;
        if (mode_q == TRAIN) begin
          if (smp_last) begin
            state_nx = SET_CLOSE;
          end else begin
            smp_inc  = 1'b1;
            state_nx = ACCUM;
          end
        end else begin
          state_nx = WAIT_PRED;
        end
      end
      SET_CLOSE: begin
        dp_set_clr = 1'b1;
        state_nx   = IDLE;
      end
      WAIT_PRED: begin
        lat_en = 1'b1;
        if (lat_last) begin
          capture  = 1'b1;
          state_nx = RESULT;
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (smp_last) begin
            state_nx = IDLE;
          end else begin
            smp_inc  = 1'b1;
            state_nx = ACCUM;
          end
        end
      end
      default: state_nx = FLUSH;
    endcase
    // Abort kills every side effect of the current cycle, including a pending commit
    if (abort_act) begin
      state_nx   = FLUSH;
      feat_ready = 1'b0;
      dp_smp_clr = 1'b0;
      dp_set_clr = 1'b0;
      res_valid  = 1'b0;
      smp_inc    = 1'b0;
      lat_en     = 1'b0;
      capture    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= PREDICT;
      dp_label  <= '0;
      job_cnt   <= '0;
      res_class <= '0;
    end else begin
      if (accept) begin
        mode_q   <= cmd_mode;
        dp_label <= cmd_label;
        job_cnt  <= cmd_smp_cnt;
      end
      if (capture) res_class <= dp_predict;
    end
  end

  rchdc_cnt #(.W(FW), .MAX(FW'(FEAT_NUM - 1))) u_feat_cnt (
    .clk(clk), .rst(rst), .clr(accept), .en(dp_smp_en), .cnt(feat_idx)
  );

  rchdc_cnt #(.W(SMP_CNT_W), .MAX('1)) u_smp_cnt (
    .clk(clk), .rst(rst), .clr(accept), .en(smp_inc), .cnt(smp_idx)
  );

  rchdc_cnt #(.W(LW), .MAX(LW'(PRED_LAT - 1))) u_lat_cnt (
    .clk(clk), .rst(rst), .clr(lat_clr), .en(lat_en), .cnt(lat_cnt)
  );
endmodule

`default_nettype wire

// File: doc/rchdc_seq_ctrl.md
# rchdc_seq_ctrl

Sequencer for the RCHDC hyperdimensional classifier datapath. Accepts train/predict jobs on a command channel and streams features into the datapath through a valid/ready handshake. Generates the `smp_en`/`smp_clr`/`set_clr`/`state`/`label` control that closes samples and commits class sets to the AM. In predict mode it captures the datapath's `predict` output and returns one result per sample over a valid/ready channel.

## Interface
- FEAT_NUM, 784: features per sample (≥1).
- SMP_CNT_W, 16: width of the job sample count.
- PRED_LAT, 2: cycles from the `smp_clr` pulse (predict) to a valid datapath `predict`.
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1  job handshake.
- cmd_mode  in  1  `TRAIN` or `PREDICT` (package encoding).
- cmd_label  in  CLS_DW  class for a train job; ignored in predict.
- cmd_smp_cnt  in  SMP_CNT_W  samples in the job.
- feat_valid / feat_ready  in / out  1  feature handshake; `im_value`/`im_pos` are supplied externally alongside.
- feat_idx  out  $clog2(FEAT_NUM)  index of the next feature, used to address the position item memory.
- dp_state  out  1  datapath `state`.
- dp_smp_en, dp_smp_clr, dp_set_clr  out  1  datapath strobes.
- dp_label  out  CLS_DW  datapath `label`.
- dp_predict  in  CLS_DW  datapath `predict`.
- res_valid / res_ready  out / in  1  result handshake.
- res_class  out  CLS_DW  predicted class.
- res_smp  out  SMP_CNT_W  sample index within the job.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: FLUSH, IDLE, ACCUM, CLOSE, SET_CLOSE, WAIT_PRED, RESULT.
- FLUSH: the state entered on reset. Lasts one cycle.
  - Drives `dp_state=PREDICT`, `dp_smp_clr=1`, `dp_set_clr=1`, which clears both encoders without an AM write.
  - Then goes to IDLE.
- IDLE: `cmd_ready=1`. On `cmd_valid`, latches mode, label and count, and zeroes the feature and sample counters.
  - Count 0: the job is accepted and the FSM stays in IDLE (no-op).
  - Otherwise: goes to ACCUM.
- ACCUM: `feat_ready=1`.
  - `dp_smp_en = feat_valid & feat_ready`, combinational.
  - Each accepted feature increments `feat_idx`.
  - Acceptance at `feat_idx==FEAT_NUM-1` wraps the counter to 0 and goes to CLOSE.
- CLOSE: `dp_smp_clr=1` for exactly one cycle. `dp_label` and `dp_state` are stable from job accept onward.
  - Train, last sample: goes to SET_CLOSE.
  - Train, not last: increments the sample counter and returns to ACCUM.
  - Predict: goes to WAIT_PRED.
- SET_CLOSE: `dp_set_clr=1` for one cycle with `dp_state=TRAIN`, which commits AM[label]. Then goes to IDLE.
- WAIT_PRED: counts PRED_LAT cycles, then registers `dp_predict` into `res_class` and goes to RESULT.
- RESULT: `res_valid=1`, with `res_class`/`res_smp` held until `res_ready`.
  - On handshake, last sample: goes to IDLE.
  - On handshake, not last: increments the sample counter and returns to ACCUM.
- `dp_state` outside a job holds the last job's mode. `dp_state` equals PREDICT after reset.
- Counters wrap modulo their width. A sample is last when `smp_cnt == cmd_smp_cnt-1`.

## Timing
- Reset values:
  - `cmd_ready=0`, `feat_ready=0`, `res_valid=0`, `busy=1` (FLUSH).
  - `res_class=0`, `res_smp=0`, `feat_idx=0`, `dp_label=0`, `dp_state=PREDICT`.
  - `dp_smp_en=0`.
  - `dp_smp_clr=0` and `dp_set_clr=0`, except during the FLUSH cycle.
- After rst deasserts: FLUSH runs in cycle 0 and `cmd_ready` rises in cycle 1.
- `dp_smp_clr` asserts in the cycle after the last feature handshake.
- `dp_set_clr` asserts in the cycle after that `dp_smp_clr`. It is never coincident with `dp_smp_clr` outside FLUSH.
- Predict latency, last-feature handshake to `res_valid`: 1 + PRED_LAT + 1 cycles. This is 4 with the default.
- Train sample-to-sample gap: 1 idle cycle (CLOSE).
- `feat_valid` while `feat_ready=0` is ignored and never counted.
- rst mid-job: the job is abandoned, no partial AM commit occurs, and FLUSH runs.

## Configuration
- RCHDC_CTRL_ABORT_EN defined: adds port `abort  in  1`.
  - In any state other than FLUSH or IDLE, `abort` goes to FLUSH next cycle.
  - A pending result is dropped and no `set_clr` with `TRAIN` is issued.
  - `abort` in IDLE is ignored.
- Undefined: no port; jobs always run to completion.

## Structure
- Shared package `rchdc_pkg` holds:
  - `TRAIN`/`PREDICT` encodings, `CLS_DW`, `CLS_NUM`, `DIM`.
  - The FSM enum `rchdc_ctrl_state_e`.
- One sub-module, `rchdc_cnt`: a generic wrap-at-max up-counter with clear/enable. It is instantiated for the feature, sample and latency counters.

## Test plan
- Reset: 1 cycle of rst → next cycle `dp_smp_clr=1`, `dp_set_clr=1`, `dp_state=PREDICT`; following cycle `cmd_ready=1`, all strobes 0.
- Train job with FEAT_NUM=4, label=2, count=3, `feat_valid` held high:
  - `dp_smp_en` high for 4 cycles, 3 times.
  - 3 `dp_smp_clr` pulses with `dp_label=2`.
  - 1 `dp_set_clr` in the cycle after the third `dp_smp_clr`.
  - Then `cmd_ready=1`.
- Predict job with count=2 and `dp_predict` forced to 5 then 7:
  - Results (5, 0) and (7, 1), each arriving 4 cycles after its last feature.
  - `dp_set_clr` never asserts.
- Backpressure: `res_ready` low for 10 cycles → `res_valid` and `res_class` held stable, `feat_ready=0` throughout, no extra strobes.
- Zero-count command → accepted in 1 cycle, FSM stays IDLE, no `dp_*` strobes.
- rst asserted mid-ACCUM of a train job (and `abort` with RCHDC_CTRL_ABORT_EN) → FLUSH pulse with `dp_state=PREDICT`, no `dp_set_clr` while `dp_state=TRAIN`.
